ysyx_22041752_rf_wport_arb: RTL
===============================

# ysyx_22041752_rf_wport_arb

Arbiter and scheduler for the single register-file write port, which is shared by two writers: the in-order pipeline writeback stage and a long-latency unit (LU: multiplier, divider). The block buffers LU results in a 2-entry FIFO and grants the port with starvation-bounded priority. It also keeps a 32-entry pending-destination scoreboard, which the decode stage uses to stall RAW/WAW hazards on LU destinations. It sits between the writeback stage and the register file, replacing the direct writeback-to-register-file connection.

## Interface
- ADDR_WD, 5, register address width.
- DATA_WD, 64, register data width.
- STARVE_MAX, 4, number of consecutive lost arbitration cycles after which the LU FIFO head is forced through; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ws_rf_we  in  1  pipeline writeback request. Already qualified with the writeback-stage valid.
- ws_rf_waddr  in  ADDR_WD  pipeline destination register.
- ws_rf_wdata  in  DATA_WD  pipeline write data.
- ws_wb_ready  out  1  pipeline write granted this cycle. The writeback stage's ready_go is driven from this signal.
- lu_issue_valid  in  1  LU operation issued this cycle.
- lu_issue_rd  in  ADDR_WD  destination register of the issued LU operation.
- lu_issue_ready  out  1  issue accepted; equals !sb_busy[lu_issue_rd].
- lu_wb_valid  in  1  LU result valid.
- lu_wb_rd  in  ADDR_WD  LU result destination register.
- lu_wb_data  in  DATA_WD  LU result data.
- lu_wb_ready  out  1  FIFO not full.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_WD  register-file write address.
- rf_wdata  out  DATA_WD  register-file write data.
- sb_busy  out  32  registered pending mask. Bit i set means an LU write to register xi is outstanding.

## Operation
- FIFO: 2 entries {rd, data}, with registered head/tail pointers and a 2-bit count. The count states are EMPTY(0), ONE(1) and FULL(2).
  - Push when lu_wb_valid && lu_wb_ready.
  - Pop when the head is granted.
  - Simultaneous push and pop in ONE or FULL leaves the count unchanged.
  - In FULL, lu_wb_ready=0; a pop in the same cycle does not raise it (no same-cycle reuse).
- Grant rule, evaluated each cycle. Let head_v = count≠0.
  - No request (!ws_rf_we && !head_v): rf_we=0, ws_wb_ready=1.
  - Pipeline only: grant the pipeline.
  - Head only: grant the head.
  - Both, with starve_cnt<STARVE_MAX: grant the pipeline and increment starve_cnt.
  - Both, with starve_cnt==STARVE_MAX: grant the head and set ws_wb_ready=0, stalling the pipeline one cycle.
- ws_wb_ready is 1 whenever the pipeline is granted or ws_rf_we=0.
- starve_cnt: 4-bit. It clears on a head grant or when the FIFO is empty, and saturates at STARVE_MAX.
- Output mux: the granted source drives rf_waddr and rf_wdata.
  - rf_we=1 for a granted source unless its address is x0.
  - A head with rd=0 still pops, with rf_we=0.
- Scoreboard:
  - Sets bit rd on lu_issue_valid && lu_issue_ready && rd≠0.
  - Clears bit rd when the FIFO head is granted.
  - Set and clear of different bits in the same cycle both take effect.
  - Set and clear of the same bit in one cycle cannot occur, because issue is blocked while the bit is busy.
  - Bit 0 is always 0.
- Pipeline writes never touch the scoreboard. Decode must stall a pipeline instruction whose rd is busy (WAW).

## Timing
- While reset is low: count=EMPTY, pointers=0, starve_cnt=0, sb_busy=0, rf_we=0, ws_wb_ready=1, lu_wb_ready=1, lu_issue_ready=1, rf_waddr=0, rf_wdata=0. Outputs are forced regardless of inputs.
- Reset asserted mid-operation discards buffered LU results and pending bits immediately. The LU must be flushed by the same reset.
- LU result latency: an accepted result reaches the port no earlier than the next cycle (no bypass). Its scoreboard bit drops one cycle after the write.
- Pipeline write latency: combinational, same cycle as ws_rf_we when granted.
- Worst-case pipeline stall: one cycle per forced head grant, i.e. at most 1 stall per STARVE_MAX+1 cycles per buffered entry.

## Structure
- The shared header defines ADDR_WD/DATA_WD defaults consistent with the RF_ADDR_WD/RF_DATA_WD macros, plus the STARVE_MAX default.
- Sub-module ysyx_22041752_wb_fifo2 contains the 2-entry FIFO (count, pointers, full/empty flags). The arbiter, starvation counter and scoreboard stay in the top module.

## Test plan
- After reset release, issue x5, then lu_wb x5=0xDEAD one cycle later with no pipeline traffic -> sb_busy[5]=1 from the cycle after issue; rf_we=1, waddr=5, wdata=0xDEAD one cycle after the wb handshake; sb_busy[5]=0 the following cycle.
- Continuous ws_rf_we to x1 with one buffered LU result for x7, STARVE_MAX=4 -> the pipeline is granted 4 cycles; on the 5th, ws_wb_ready=0 and rf writes x7; the pipeline resumes next cycle.
- Push 2 LU results under continuous pipeline writes -> lu_wb_ready=0 while FULL; a third lu_wb_valid is held until a pop, and the entry is accepted the cycle after the pop.
- lu_issue x3 while sb_busy[3]=1 -> lu_issue_ready=0 and the bit stays set; issue x0 -> accepted and sb_busy unchanged; an LU wb to x0 -> FIFO pops with rf_we=0.
- Reset asserted low with FIFO FULL and sb_busy≠0 -> all outputs take reset values in the same cycle; after release, the first pipeline write is granted immediately.

Source files
------------

// File: rtl/ysyx_22041752_rf_wport_arb_pkg.sv
// Shared widths, defaults and small types for the register-file write-port arbiter.
// The width defaults track the RF_ADDR_WD / RF_DATA_WD values used by the core.
package ysyx_22041752_rf_wport_arb_pkg;

  localparam int unsigned RF_ADDR_WD    = 5;
  localparam int unsigned RF_DATA_WD    = 64;
  localparam int unsigned RF_STARVE_MAX = 4;
  localparam int unsigned NUM_REGS      = 32;

  typedef enum logic [1:0] {
    CntEmpty = 2'd0,
    CntOne   = 2'd1,
    CntFull  = 2'd2
  } fifo_cnt_e;

  typedef enum logic [1:0] {
    GntNone = 2'd0,
    GntPipe = 2'd1,
    GntHead = 2'd2
  } gnt_e;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/ysyx_22041752_wb_fifo2.sv
// Two-entry FIFO buffering long-latency unit results ({rd, data}) ahead of the write port.
// Ready is taken from the registered count only, so a pop never frees a slot in the same cycle.
module ysyx_22041752_wb_fifo2
  import ysyx_22041752_rf_wport_arb_pkg::*;
#(
  parameter int unsigned ADDR_WD = RF_ADDR_WD,
  parameter int unsigned DATA_WD = RF_DATA_WD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_valid,
  input  logic [ADDR_WD-1:0] push_rd,
  input  logic [DATA_WD-1:0] push_data,
  output logic               push_ready,
  input  logic               pop,
  output logic               head_valid,
  output logic [ADDR_WD-1:0] head_rd,
  output logic [DATA_WD-1:0] head_data
);

  fifo_cnt_e          count_q, count_d;
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [ADDR_WD-1:0] rd_q   [2];
  logic [DATA_WD-1:0] data_q [2];
  logic               full, empty;
  logic               push_en, pop_en;

  assign full       = (count_q == CntFull);
  assign empty      = (count_q == CntEmpty);
  assign push_ready = !full;
  assign head_valid = !empty;
  assign head_rd    = rd_q[rptr_q];
  assign head_data  = data_q[rptr_q];
  assign push_en    = push_valid && !full;
  assign pop_en     = pop && !empty;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push_en) wptr_d = !wptr_q;
    if (pop_en)  rptr_d = !rptr_q;
    if (push_en && !pop_en) begin
      count_d = (count_q == CntEmpty) ? CntOne : CntFull;
    end else if (!push_en && pop_en) begin
      count_d = (count_q == CntFull) ? CntOne : CntEmpty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= CntEmpty;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      if (push_en) begin
        rd_q[wptr_q]   <= push_rd;
        data_q[wptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041752_rf_wport_arb.sv
// Shares the single register-file write port between the writeback stage and buffered
// long-latency results, and tracks outstanding long-latency destinations for decode.
module ysyx_22041752_rf_wport_arb
  import ysyx_22041752_rf_wport_arb_pkg::*;
#(
  parameter int unsigned ADDR_WD    = RF_ADDR_WD,
  parameter int unsigned DATA_WD    = RF_DATA_WD,
  parameter int unsigned STARVE_MAX = RF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ws_rf_we,
  input  logic [ADDR_WD-1:0]  ws_rf_waddr,
  input  logic [DATA_WD-1:0]  ws_rf_wdata,
  output logic                ws_wb_ready,
  input  logic                lu_issue_valid,
  input  logic [ADDR_WD-1:0]  lu_issue_rd,
  output logic                lu_issue_ready,
  input  logic                lu_wb_valid,
  input  logic [ADDR_WD-1:0]  lu_wb_rd,
  input  logic [DATA_WD-1:0]  lu_wb_data,
  output logic                lu_wb_ready,
  output logic                rf_we,
  output logic [ADDR_WD-1:0]  rf_waddr,
  output logic [DATA_WD-1:0]  rf_wdata,
  output logic [NUM_REGS-1:0] sb_busy
);

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  logic               fifo_ready, head_valid;
  logic [ADDR_WD-1:0] head_rd;
  logic [DATA_WD-1:0] head_data;
  gnt_e               gnt;
  logic [3:0]         starve_q, starve_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic               issue_ok;

  ysyx_22041752_wb_fifo2 #(
    .ADDR_WD (ADDR_WD),
    .DATA_WD (DATA_WD)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (lu_wb_valid),
    .push_rd    (lu_wb_rd),
    .push_data  (lu_wb_data),
    .push_ready (fifo_ready),
    .pop        (gnt == GntHead),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data)
  );

  always_comb begin
    gnt = GntNone;
    if (ws_rf_we && head_valid) begin
      gnt = (starve_q >= StarveLim) ? GntHead : GntPipe;
    end else if (ws_rf_we) begin
      gnt = GntPipe;
    end else if (head_valid) begin
      gnt = GntHead;
    end
  end

  // Only counts cycles where a waiting head actually lost to the pipeline.
  always_comb begin
    starve_d = sat_inc(starve_q, StarveLim);
    if (!head_valid || gnt == GntHead) starve_d = 4'd0;
  end

  // Outputs are held at their idle values while reset is low, whatever the inputs do.
  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    ws_wb_ready = 1'b1;
    if (reset) begin
      unique case (gnt)
        GntPipe: begin
          rf_we    = (ws_rf_waddr != '0);
          rf_waddr = ws_rf_waddr;
          rf_wdata = ws_rf_wdata;
        end
        GntHead: begin
          rf_we       = (head_rd != '0);
          rf_waddr    = head_rd;
          rf_wdata    = head_data;
          ws_wb_ready = !ws_rf_we;
        end
        default: ;
      endcase
    end
  end

  assign issue_ok       = lu_issue_valid && !sb_q[lu_issue_rd];
  assign lu_issue_ready = !reset || !sb_q[lu_issue_rd];
  assign lu_wb_ready    = !reset || fifo_ready;
  assign sb_busy        = sb_q;

  always_comb begin
    sb_d = sb_q;
    if (issue_ok && lu_issue_rd != '0) sb_d[lu_issue_rd] = 1'b1;
    if (gnt == GntHead) sb_d[head_rd] = 1'b0;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= 4'd0;
      sb_q     <= '0;
    end else begin
      starve_q <= starve_d;
      sb_q     <= sb_d;
    end
  end

endmodule
